// File: rtl/vdp_reg_write_arbiter.sv
// vdp_reg_write_arbiter: merges host writes and FIFO-buffered copper writes onto one registered register-file write port (define VDP_ARB_COPPER_BYPASS_EN for empty-FIFO copper bypass)
module vdp_reg_write_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int HOST_BURST_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_write_en,
  input  logic [5:0]  host_write_address,
  input  logic [15:0] host_write_data,
  output logic        host_write_ready,
  input  logic        copper_write_en,
  input  logic [5:0]  copper_write_address,
  input  logic [15:0] copper_write_data,
  output logic        copper_write_ready,
  output logic        copper_overflow,
  output logic        reg_write_en,
  output logic [5:0]  reg_write_address,
  output logic [15:0] reg_write_data
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = HOST_BURST_MAX > 0 ? $clog2(HOST_BURST_MAX + 1) : 1;
  logic [21:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [BW-1:0] burst;
  logic fifo_empty, fifo_full, host_grant, copper_grant, bypass, push, grant_any;
  always_comb begin
    fifo_empty = count == '0;
    fifo_full = count == (AW+1)'(FIFO_DEPTH);
    host_grant = host_write_en && (fifo_empty || burst < BW'(HOST_BURST_MAX));
    copper_grant = !host_grant && !fifo_empty;
`ifdef VDP_ARB_COPPER_BYPASS_EN
    bypass = fifo_empty && copper_write_en && !host_grant;
`else
    bypass = 1'b0;
`endif
    push = copper_write_en && !fifo_full && !bypass;
    grant_any = host_grant || copper_grant || bypass;
    host_write_ready = host_grant;
    copper_write_ready = !fifo_full;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {copper_write_address, copper_write_data};
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      burst <= '0;
      copper_overflow <= 1'b0;
      reg_write_en <= 1'b0;
      reg_write_address <= '0;
      reg_write_data <= '0;
    end else begin
      count <= count + (AW+1)'(push) - (AW+1)'(copper_grant);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (copper_grant) rd_ptr <= rd_ptr + AW'(1);
      if (copper_write_en && fifo_full) copper_overflow <= 1'b1;
      if (copper_grant || fifo_empty) burst <= '0;
      else if (host_grant && burst < BW'(HOST_BURST_MAX)) burst <= burst + BW'(1);
      reg_write_en <= grant_any;
      if (grant_any)
        {reg_write_address, reg_write_data} <= host_grant ? {host_write_address, host_write_data} :
                                               copper_grant ? mem[rd_ptr] :
                                               {copper_write_address, copper_write_data};
    end
  end
endmodule
